// File: rtl/tbox_arbiter_if.sv
// Bundle for the shared T-box arbiter: two lookup requesters, the ROM bank port and the response side.
interface tbox_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [1:0]  req0_sel;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [1:0]  req1_sel;
    logic        req1_ready;
    logic [7:0]  rom_a;
    logic [1:0]  rom_sel;
    logic [31:0] rom_q;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_sel,
        input  req1_valid, req1_a, req1_sel,
        input  rom_q,
        output req0_ready, req1_ready,
        output rom_a, rom_sel,
        output rsp0_valid, rsp1_valid, rsp_data, busy
    );

    modport master (
        output req0_valid, req0_a, req0_sel,
        output req1_valid, req1_a, req1_sel,
        output rom_q,
        input  req0_ready, req1_ready,
        input  rom_a, rom_sel,
        input  rsp0_valid, rsp1_valid, rsp_data, busy
    );
endinterface

// File: rtl/tbox_arbiter.sv
// Round-robin arbiter sharing one inverse T-box ROM between two requesters;
// responses return in acceptance order ROM_LAT+1 cycles after the grant.
module tbox_arbiter #(
    parameter int unsigned ROM_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    tbox_arbiter_if.slave bus
);
    // 1 when requester 1 won the most recent accepted lookup
    logic               last_grant;
    logic               grant1;
    logic               ready0;
    logic               ready1;
    logic               accept;
    logic [ROM_LAT-1:0] tag_v;
    logic [ROM_LAT-1:0] tag_id;
    logic               tail_v;
    logic               tail_id;
    logic               rsp0_q;
    logic               rsp1_q;
    logic [31:0]        rsp_data_q;

    always_comb begin
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        ready0 = !rst && bus.req0_valid && !grant1;
        ready1 = !rst && grant1;
        accept = ready0 || ready1;
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rom_a      = grant1 ? bus.req1_a   : (bus.req0_valid ? bus.req0_a   : '0);
    assign bus.rom_sel    = grant1 ? bus.req1_sel : (bus.req0_valid ? bus.req0_sel : '0);

    assign tail_v  = tag_v[ROM_LAT-1];
    assign tail_id = tag_id[ROM_LAT-1];

    // Tag pipeline tracks rom_q; the oldest tag qualifies the word captured from the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            tag_v      <= '0;
            tag_id     <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant1;
            end
            tag_v  <= ROM_LAT'({tag_v, accept});
            tag_id <= ROM_LAT'({tag_id, grant1});
            rsp0_q <= tail_v && !tail_id;
            rsp1_q <= tail_v && tail_id;
            if (tail_v) begin
                rsp_data_q <= bus.rom_q;
            end
        end
    end

    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = !rst && ((|tag_v) || rsp0_q || rsp1_q);
endmodule

// File: tb/tb_tbox_arbiter.sv
// Bench for tbox_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share stimulus; a reference
// arbiter plus response scoreboard runs on both, alongside directed and table-driven checks.
module tb_tbox_arbiter;
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
        int          born;
    } exp_t;

    typedef struct {
        logic       v0;
        logic [7:0] a0;
        logic [1:0] s0;
        logic       v1;
        logic [7:0] a1;
        logic [1:0] s1;
        logic       r0;
        logic       r1;
        logic [7:0] ra;
        logic [1:0] rs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t        sbq [2][$];
    logic        m_lg [2];
    logic [31:0] m_data [2];
    vec_t        vecs [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tbox_arbiter_if bus1 ();
    tbox_arbiter_if bus3 ();

    tbox_arbiter #(.ROM_LAT(1)) dut  (.clk(clk), .rst(rst), .bus(bus1.slave));
    tbox_arbiter #(.ROM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    function automatic logic [31:0] td0(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h51f4a750;
            8'h01:   return 32'h7e416553;
            8'h02:   return 32'h1a17a4c3;
            8'h03:   return 32'h3a275e96;
            8'h04:   return 32'h3bab6bcb;
            8'h05:   return 32'h1f9d45f1;
            8'h06:   return 32'hacfa58ab;
            8'h07:   return 32'h4be30393;
            8'hff:   return 32'hd0b85742;
            default: return {a, ~a, a ^ 8'h5a, a + 8'd1};
        endcase
    endfunction

    // Td1..Td3 are byte rotations of Td0
    function automatic logic [31:0] tbox(input logic [7:0] a, input logic [1:0] sel);
        logic [31:0] w;
        w = td0(a);
        case (sel)
            2'd0:    return w;
            2'd1:    return {w[7:0],  w[31:8]};
            2'd2:    return {w[15:0], w[31:16]};
            default: return {w[23:0], w[31:24]};
        endcase
    endfunction

    logic [31:0] rom1_q;
    logic [31:0] rom3_p [3];
    always @(posedge clk) begin
        rom1_q    <= tbox(bus1.rom_a, bus1.rom_sel);
        rom3_p[0] <= tbox(bus3.rom_a, bus3.rom_sel);
        rom3_p[1] <= rom3_p[0];
        rom3_p[2] <= rom3_p[1];
    end
    assign bus1.rom_q = rom1_q;
    assign bus3.rom_q = rom3_p[2];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor(input int k, input int lat,
                           input logic v0, input logic [7:0] a0, input logic [1:0] s0,
                           input logic v1, input logic [7:0] a1, input logic [1:0] s1,
                           input logic r0, input logic r1,
                           input logic [7:0] ra, input logic [1:0] rs,
                           input logic p0, input logic p1,
                           input logic [31:0] rd, input logic bz);
        logic g1;
        logic any;
        logic mb;
        logic due_now;
        exp_t e;
        string pfx;
        pfx = $sformatf("lat%0d_", lat);
        if (rst) begin
            check_bit({pfx, "rst_ready0"}, r0, 1'b0);
            check_bit({pfx, "rst_ready1"}, r1, 1'b0);
            check_bit({pfx, "rst_busy"}, bz, 1'b0);
            sbq[k].delete();
            m_lg[k]   = 1'b1;
            m_data[k] = '0;
            return;
        end
        g1  = v1 && (!v0 || !m_lg[k]);
        any = v0 || v1;
        check_bit({pfx, "ready0"}, r0, v0 && !g1);
        check_bit({pfx, "ready1"}, r1, g1);
        check32({pfx, "rom_a"}, 32'(ra), any ? 32'(g1 ? a1 : a0) : 32'd0);
        check32({pfx, "rom_sel"}, 32'(rs), any ? 32'(g1 ? s1 : s0) : 32'd0);

        mb = 1'b0;
        for (int i = 0; i < sbq[k].size(); i++) begin
            if (sbq[k][i].born < cyc) mb = 1'b1;
        end
        check_bit({pfx, "busy"}, bz, mb);
        check_bit({pfx, "rsp_exclusive"}, p0 && p1, 1'b0);

        due_now = (sbq[k].size() > 0) && (sbq[k][0].due <= cyc);
        check_bit({pfx, "rsp_present"}, p0 || p1, due_now);
        if (due_now) begin
            e = sbq[k].pop_front();
            if (p0 || p1) begin
                check_bit({pfx, "rsp_id"}, p1, e.id);
                check32({pfx, "rsp_data"}, rd, e.data);
            end
            m_data[k] = e.data;
        end else if (!(p0 || p1)) begin
            check32({pfx, "rsp_hold"}, rd, m_data[k]);
        end

        if (any) begin
            e.id   = g1;
            e.data = tbox(g1 ? a1 : a0, g1 ? s1 : s0);
            e.due  = cyc + lat + 1;
            e.born = cyc;
            sbq[k].push_back(e);
            m_lg[k] = g1;
        end
    endtask

    always @(negedge clk) begin
        monitor(0, 1, bus1.req0_valid, bus1.req0_a, bus1.req0_sel,
                bus1.req1_valid, bus1.req1_a, bus1.req1_sel,
                bus1.req0_ready, bus1.req1_ready, bus1.rom_a, bus1.rom_sel,
                bus1.rsp0_valid, bus1.rsp1_valid, bus1.rsp_data, bus1.busy);
        monitor(1, 3, bus3.req0_valid, bus3.req0_a, bus3.req0_sel,
                bus3.req1_valid, bus3.req1_a, bus3.req1_sel,
                bus3.req0_ready, bus3.req1_ready, bus3.rom_a, bus3.rom_sel,
                bus3.rsp0_valid, bus3.rsp1_valid, bus3.rsp_data, bus3.busy);
    end

    task automatic drive(input logic v0, input logic [7:0] a0, input logic [1:0] s0,
                         input logic v1, input logic [7:0] a1, input logic [1:0] s1);
        bus1.req0_valid = v0; bus1.req0_a = a0; bus1.req0_sel = s0;
        bus1.req1_valid = v1; bus1.req1_a = a1; bus1.req1_sel = s1;
        bus3.req0_valid = v0; bus3.req0_a = a0; bus3.req0_sel = s0;
        bus3.req1_valid = v1; bus3.req1_a = a1; bus3.req1_sel = s1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle();
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected test completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hold;
        int j;

        vecs[0]  = '{1'b0, 8'haa, 2'd1, 1'b0, 8'hbb, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 8'h00, 2'd3, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00, 2'd3};
        vecs[2]  = '{1'b1, 8'h01, 2'd3, 1'b1, 8'hff, 2'd3, 1'b0, 1'b1, 8'hff, 2'd3};
        vecs[3]  = '{1'b1, 8'h01, 2'd3, 1'b1, 8'hff, 2'd3, 1'b1, 1'b0, 8'h01, 2'd3};
        vecs[4]  = '{1'b1, 8'h01, 2'd3, 1'b1, 8'hff, 2'd3, 1'b0, 1'b1, 8'hff, 2'd3};
        vecs[5]  = '{1'b1, 8'h01, 2'd3, 1'b1, 8'hff, 2'd3, 1'b1, 1'b0, 8'h01, 2'd3};
        vecs[6]  = '{1'b0, 8'h00, 2'd0, 1'b1, 8'h10, 2'd2, 1'b0, 1'b1, 8'h10, 2'd2};
        vecs[7]  = '{1'b0, 8'h00, 2'd0, 1'b1, 8'h11, 2'd1, 1'b0, 1'b1, 8'h11, 2'd1};
        vecs[8]  = '{1'b1, 8'h22, 2'd0, 1'b1, 8'h33, 2'd1, 1'b1, 1'b0, 8'h22, 2'd0};
        vecs[9]  = '{1'b1, 8'h44, 2'd1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h44, 2'd1};
        vecs[10] = '{1'b1, 8'h55, 2'd2, 1'b1, 8'h66, 2'd3, 1'b0, 1'b1, 8'h66, 2'd3};
        vecs[11] = '{1'b0, 8'h77, 2'd2, 1'b0, 8'h88, 2'd1, 1'b0, 1'b0, 8'h00, 2'd0};

        idle();
        do_reset(3);

        // Contention from reset: grants 0,1,0,1; responses at +2 (lat 1) and +4 (lat 3)
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1'b1, 8'h01, 2'd3, 1'b1, 8'hff, 2'd3);
            else idle();
            @(negedge clk);
            if (i < 4) begin
                check_bit("cont_ready0", bus1.req0_ready, (i % 2) == 0);
                check_bit("cont_ready1", bus1.req1_ready, (i % 2) == 1);
            end
            if (i >= 2 && i <= 5) begin
                j = i - 2;
                check_bit("cont_rsp0_l1", bus1.rsp0_valid, (j % 2) == 0);
                check_bit("cont_rsp1_l1", bus1.rsp1_valid, (j % 2) == 1);
                check32("cont_data_l1", bus1.rsp_data, (j % 2) == 0 ? 32'h4165537e : 32'hb85742d0);
            end
            if (i >= 4) begin
                j = i - 4;
                check_bit("cont_rsp0_l3", bus3.rsp0_valid, (j % 2) == 0);
                check_bit("cont_rsp1_l3", bus3.rsp1_valid, (j % 2) == 1);
                check32("cont_data_l3", bus3.rsp_data, (j % 2) == 0 ? 32'h4165537e : 32'hb85742d0);
            end
            step();
        end

        // Single lookup
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1'b1, 8'h00, 2'd3, 1'b0, 8'h00, 2'd0);
            else idle();
            @(negedge clk);
            if (i == 0) begin
                check_bit("single_ready0", bus1.req0_ready, 1'b1);
                check32("single_rom_a", 32'(bus1.rom_a), 32'h00);
                check32("single_rom_sel", 32'(bus1.rom_sel), 32'd3);
            end
            if (i == 1) check_bit("single_early", bus1.rsp0_valid, 1'b0);
            if (i == 2) begin
                check_bit("single_rsp0", bus1.rsp0_valid, 1'b1);
                check_bit("single_rsp1", bus1.rsp1_valid, 1'b0);
                check32("single_data", bus1.rsp_data, 32'hf4a75051);
            end
            if (i == 4) begin
                check_bit("single_rsp0_l3", bus3.rsp0_valid, 1'b1);
                check32("single_data_l3", bus3.rsp_data, 32'hf4a75051);
            end
            step();
        end

        // Streaming on requester 1
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(1'b0, 8'h00, 2'd0, 1'b1, 8'(i), 2'd3);
            else idle();
            @(negedge clk);
            if (i < 8) check_bit("stream_ready1", bus1.req1_ready, 1'b1);
            if (i >= 2 && i <= 9) begin
                check_bit("stream_rsp1", bus1.rsp1_valid, 1'b1);
                check_bit("stream_rsp0", bus1.rsp0_valid, 1'b0);
                check32("stream_data", bus1.rsp_data, tbox(8'(i - 2), 2'd3));
            end
            if (i == 10) check_bit("stream_end", bus1.rsp1_valid, 1'b0);
            step();
        end

        // Table-driven grant/address vectors
        do_reset(2);
        foreach (vecs[n]) begin
            drive(vecs[n].v0, vecs[n].a0, vecs[n].s0, vecs[n].v1, vecs[n].a1, vecs[n].s1);
            @(negedge clk);
            check_bit($sformatf("vec%0d_ready0", n), bus1.req0_ready, vecs[n].r0);
            check_bit($sformatf("vec%0d_ready1", n), bus1.req1_ready, vecs[n].r1);
            check32($sformatf("vec%0d_rom_a", n), 32'(bus1.rom_a), 32'(vecs[n].ra));
            check32($sformatf("vec%0d_rom_sel", n), 32'(bus1.rom_sel), 32'(vecs[n].rs));
            step();
        end
        idle();
        repeat (6) step();

        // Reset while a lookup is in flight
        drive(1'b1, 8'h05, 2'd0, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        check_bit("mid_accept", bus1.req0_ready, 1'b1);
        step();
        rst = 1'b1;
        drive(1'b1, 8'h06, 2'd1, 1'b1, 8'h07, 2'd2);
        @(negedge clk);
        check_bit("mid_rst_ready0", bus1.req0_ready, 1'b0);
        check_bit("mid_rst_ready1", bus1.req1_ready, 1'b0);
        check_bit("mid_rst_busy", bus1.busy, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 8'h08, 2'd0, 1'b1, 8'h09, 2'd0);
        @(negedge clk);
        check_bit("mid_no_rsp0", bus1.rsp0_valid, 1'b0);
        check_bit("mid_first_grant0", bus1.req0_ready, 1'b1);
        check_bit("mid_first_grant1", bus1.req1_ready, 1'b0);
        step();
        idle();
        @(negedge clk);
        check_bit("mid_no_rsp1", bus1.rsp1_valid, 1'b0);
        step();
        repeat (6) step();

        // Idle: outputs quiet and response word held
        hold = m_data[0];
        for (int i = 0; i < 10; i++) begin
            idle();
            @(negedge clk);
            check32("idle_rom_a", 32'(bus1.rom_a), 32'd0);
            check32("idle_rom_sel", 32'(bus1.rom_sel), 32'd0);
            check_bit("idle_busy", bus1.busy, 1'b0);
            check_bit("idle_rsp0", bus1.rsp0_valid, 1'b0);
            check_bit("idle_rsp1", bus1.rsp1_valid, 1'b0);
            check32("idle_data", bus1.rsp_data, hold);
            step();
        end

        // Random traffic with occasional resets; the scoreboard does the checking
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom));
            step();
        end
        rst = 1'b0;
        idle();
        repeat (8) step();
        check32("drain_lat1", 32'(sbq[0].size()), 32'd0);
        check32("drain_lat3", 32'(sbq[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tbox_arbiter.md
TBOX_ARBITER -- requirements
Module: tbox_arbiter

Interface
REQ-001 SHALL have parameter ROM_LAT, default 1: T-box ROM read latency in clocks, legal range 1..3.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each: requester N has a lookup pending.
REQ-005 SHALL have ports req0_a / req1_a, input, 8 each: ROM byte address for requester N.
REQ-006 SHALL have ports req0_sel / req1_sel, input, 2 each: inverse table select (0..3 = Td0..Td3) for requester N.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each: lookup from requester N is accepted this cycle.
REQ-008 SHALL have port rom_a, output, 8: address to the shared T-box bank.
REQ-009 SHALL have port rom_sel, output, 2: table select to the shared bank.
REQ-010 SHALL have port rom_q, input, 32: bank data, valid ROM_LAT cycles after rom_a/rom_sel.
REQ-011 SHALL have ports rsp0_valid / rsp1_valid, output, 1 each: response pulse for requester N.
REQ-012 SHALL have port rsp_data, output, 32: shared response word, qualified by rsp0_valid or rsp1_valid.
REQ-013 SHALL have port busy, output, 1: at least one lookup is in flight.

Function
REQ-014 SHALL accept at most one lookup per cycle; acceptance = reqN_valid && reqN_ready in the same cycle.
REQ-015 SHALL compute readyN combinationally from the valids and the last-grant register; no dependency on readyN from the requester side.
REQ-016 SHALL assert only req0_ready when only req0_valid is high.
REQ-017 SHALL assert only req1_ready when only req1_valid is high.
REQ-018 SHALL use round-robin when both valids are high: grant the requester that did not win the most recent grant.
REQ-019 SHALL update the last-grant register only on an accepted lookup.
REQ-020 SHALL drive rom_a/rom_sel combinationally from the granted requester's a/sel in the accept cycle T.
REQ-021 SHALL drive rom_a/rom_sel to 0 when no requester is valid.
REQ-022 SHALL push a tag {valid, id} into a ROM_LAT-deep shift register on each accept cycle; a bubble (valid=0) is pushed otherwise.
REQ-023 SHALL register rom_q into rsp_data at cycle T+ROM_LAT, giving total latency ROM_LAT+1 from accept to response.
REQ-024 SHALL pulse rspN_valid for exactly one cycle at T+ROM_LAT+1, where N is the id of the tag leaving the shift register.
REQ-025 SHALL never assert rsp0_valid and rsp1_valid in the same cycle.
REQ-026 SHALL deliver responses in acceptance order; back-to-back accepts yield back-to-back responses at full throughput of 1 per cycle.
REQ-027 SHALL have no response backpressure; requesters are required to sink every response.
REQ-028 SHALL hold rsp_data at its last value when no response is valid.
REQ-029 SHALL drive busy = OR of all tag valid bits plus the response-stage valid.
REQ-030 SHALL allow a requester to hold valid high continuously; it is re-granted every cycle when uncontested.

Reset
REQ-031 SHALL, while rst=1, clear all tag valids, rsp0_valid, rsp1_valid, busy and rsp_data to 0.
REQ-032 SHALL, while rst=1, force req0_ready=req1_ready=0.
REQ-033 SHALL set the last-grant register to requester 1 on reset, so req0 wins the first contested cycle.
REQ-034 SHALL discard lookups in flight when rst asserts mid-operation; no response pulse appears after reset for a lookup accepted before it.

Verification
REQ-035 Single lookup, ROM_LAT=1: req0 a=0x00 sel=3 at T -> rom_a=0x00/rom_sel=3 at T; rsp0_valid=1 and rsp_data=0xf4a75051 at T+2; rsp1_valid stays 0.
REQ-036 Contention: both valid for 4 cycles from reset, req0 a=0x01, req1 a=0xff, both sel=3 -> grants 0,1,0,1; responses alternate 0x4165537e, 0xb85742d0 at T+2..T+5.
REQ-037 Streaming: req1 valid continuously for 8 cycles, a=0..7, sel=3, req0 idle -> 8 consecutive rsp1_valid pulses carrying Td3[0..7] in order; no gaps.
REQ-038 Reset mid-flight: accept req0 at T, rst=1 at T+1 -> no rsp0_valid at T+2; busy=0 and both ready=0 during reset; first contested grant after reset goes to req0.
REQ-039 ROM_LAT=3 with rom_q modelled as a 3-stage pipeline: accept at T -> response at T+4; alternating ids keep their order.
REQ-040 Idle: no valids for 10 cycles -> rom_a=0, rom_sel=0, busy=0, no response pulses, rsp_data unchanged.
